// File: rtl/main_control_unit.sv
// -----------------------------------------------------------------------------
// main_control_unit
//
// Purpose:
//   ID-stage main decoder of the 5-stage MIPS pipeline. It turns the 6-bit
//   primary opcode into the datapath control word. The word is registered so
//   that it lines up with the ID/EX pipeline boundary. The hazard unit can
//   squash the word into a bubble (all zeros) by driving i_control_mux low.
//
// Ports:
//   i_clk          system clock, rising-edge active
//   i_rst          asynchronous active-high reset; outputs go to the NOP word
//   i_opcode       instruction bits [31:26]
//   i_control_mux  1 = normal decode, 0 = force bubble (all outputs 0)
//   o_RegDst       1 = write register is rd, 0 = rt
//   o_ALUOp        ALU class: 00 add, 01 subtract, 10 use funct field
//   o_ALUSrc       1 = ALU operand B is the sign-extended immediate
//   o_Branch       conditional branch (beq)
//   o_MemRead      data-memory read enable
//   o_MemWrite     data-memory write enable
//   o_RegWrite     register-file write enable
//   o_MemtoReg     1 = write-back data comes from memory
//
// Timing:
//   Every output comes straight from a flop, so the outputs are glitch-free.
//   Latency from i_opcode / i_control_mux to the outputs is one clock. There
//   is no enable, so the registers capture on every edge.
// -----------------------------------------------------------------------------
module main_control_unit #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic                i_control_mux,
  output logic                o_RegDst,
  output logic [ALUOP_W-1:0]  o_ALUOp,
  output logic                o_ALUSrc,
  output logic                o_Branch,
  output logic                o_MemRead,
  output logic                o_MemWrite,
  output logic                o_RegWrite,
  output logic                o_MemtoReg
);

  // Primary opcodes recognised by this decoder.
  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);

  // ALU operation classes.
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = ALUOP_W'(2'b10);

  // Next-state values of the control word.
  logic               reg_dst_d;
  logic [ALUOP_W-1:0] alu_op_d;
  logic               alu_src_d;
  logic               branch_d;
  logic               mem_read_d;
  logic               mem_write_d;
  logic               reg_write_d;
  logic               mem_to_reg_d;

  // Registered control word.
  logic               reg_dst_q;
  logic [ALUOP_W-1:0] alu_op_q;
  logic               alu_src_q;
  logic               branch_q;
  logic               mem_read_q;
  logic               mem_write_q;
  logic               reg_write_q;
  logic               mem_to_reg_q;

  // Decode. Every field defaults to 0, which is the NOP word. Unknown opcodes
  // and the bubble case simply fall through to that default. Don't-care fields
  // (RegDst and MemtoReg for SW and BEQ) are left at 0 as well, so a store or
  // branch never looks like it selects rd or memory write-back downstream.
  always_comb begin
    reg_dst_d    = 1'b0;
    alu_op_d     = ALUOP_ADD;
    alu_src_d    = 1'b0;
    branch_d     = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    reg_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;

    // The bubble request overrides decode, so decode runs only when the hazard
    // unit allows it.
    if (i_control_mux) begin
      unique case (i_opcode)
        OP_RTYPE: begin
          reg_dst_d   = 1'b1;
          alu_op_d    = ALUOP_FUNCT;
          reg_write_d = 1'b1;
        end
        OP_LW: begin
          alu_src_d    = 1'b1;
          mem_read_d   = 1'b1;
          reg_write_d  = 1'b1;
          mem_to_reg_d = 1'b1;
        end
        OP_SW: begin
          alu_src_d   = 1'b1;
          mem_write_d = 1'b1;
        end
        OP_BEQ: begin
          alu_op_d = ALUOP_SUB;
          branch_d = 1'b1;
        end
        default: begin
          // Unsupported opcode: keep the NOP word so it has no side effects.
          reg_dst_d = 1'b0;
        end
      endcase
    end
  end

  // Control-word register. The reset is asynchronous so that a pipeline flush
  // takes effect immediately, without waiting for the next clock edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      reg_dst_q    <= 1'b0;
      alu_op_q     <= ALUOP_ADD;
      alu_src_q    <= 1'b0;
      branch_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      reg_dst_q    <= reg_dst_d;
      alu_op_q     <= alu_op_d;
      alu_src_q    <= alu_src_d;
      branch_q     <= branch_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  assign o_RegDst   = reg_dst_q;
  assign o_ALUOp    = alu_op_q;
  assign o_ALUSrc   = alu_src_q;
  assign o_Branch   = branch_q;
  assign o_MemRead  = mem_read_q;
  assign o_MemWrite = mem_write_q;
  assign o_RegWrite = reg_write_q;
  assign o_MemtoReg = mem_to_reg_q;

endmodule

// File: tb/tb_main_control_unit.sv
// -----------------------------------------------------------------------------
// tb_main_control_unit
//
// Bench for main_control_unit. The expected control word for each opcode comes
// from a 64-entry lookup table filled from the instruction decode table, with
// all other entries left at zero. Expected words go into a queue when a cycle is
// driven and come out after the capturing edge. Inputs change 1 time unit
// after the rising edge. Outputs are sampled 1 time unit after the edge, and
// also just before it to confirm that nothing moves early.
//
// Control word packing, MSB first:
//   {RegDst, ALUOp[1:0], ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg}
// -----------------------------------------------------------------------------
module tb_main_control_unit;

  localparam int W = 9;

  // ---------------- clock / reset ----------------
  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [5:0] i_opcode = 6'd0;
  logic       i_control_mux = 1'b1;

  logic       o_RegDst;
  logic [1:0] o_ALUOp;
  logic       o_ALUSrc;
  logic       o_Branch;
  logic       o_MemRead;
  logic       o_MemWrite;
  logic       o_RegWrite;
  logic       o_MemtoReg;

  always #5 i_clk = ~i_clk;

  main_control_unit #(
    .OPCODE_W (6),
    .ALUOP_W  (2)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_opcode      (i_opcode),
    .i_control_mux (i_control_mux),
    .o_RegDst      (o_RegDst),
    .o_ALUOp       (o_ALUOp),
    .o_ALUSrc      (o_ALUSrc),
    .o_Branch      (o_Branch),
    .o_MemRead     (o_MemRead),
    .o_MemWrite    (o_MemWrite),
    .o_RegWrite    (o_RegWrite),
    .o_MemtoReg    (o_MemtoReg)
  );

  logic [W-1:0] obs_word;
  assign obs_word = {o_RegDst, o_ALUOp, o_ALUSrc, o_Branch,
                     o_MemRead, o_MemWrite, o_RegWrite, o_MemtoReg};

  // ---------------- reference model ----------------
  logic [W-1:0] ref_table [64];

  localparam logic [W-1:0] WORD_R   = 9'b1_10_0_0_0_0_1_0;
  localparam logic [W-1:0] WORD_LW  = 9'b0_00_1_0_1_0_1_1;
  localparam logic [W-1:0] WORD_SW  = 9'b0_00_1_0_0_1_0_0;
  localparam logic [W-1:0] WORD_BEQ = 9'b0_01_0_1_0_0_0_0;

  logic [5:0] legal_ops [4];

  initial begin
    for (int i = 0; i < 64; i++) ref_table[i] = '0;
    ref_table[6'b000000] = WORD_R;
    ref_table[6'b100011] = WORD_LW;
    ref_table[6'b101011] = WORD_SW;
    ref_table[6'b000100] = WORD_BEQ;
    legal_ops[0] = 6'b000000;
    legal_ops[1] = 6'b100011;
    legal_ops[2] = 6'b101011;
    legal_ops[3] = 6'b000100;
  end

  function automatic logic [W-1:0] model_word(input logic [5:0] op, input logic mux);
    if (!mux) return '0;
    return ref_table[op];
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at time %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive one cycle from just after an edge. The outputs must still show the
  // previous word just before the next edge, and the new word just after it.
  task automatic step(input string tag, input logic [5:0] op, input logic mux);
    logic [W-1:0] exp;
    i_opcode      = op;
    i_control_mux = mux;
    exp_q.push_back(model_word(op, mux));
    #3;
    check({tag, "_hold"}, obs_word, last_exp);
    @(posedge i_clk);
    #1;
    exp = exp_q.pop_front();
    check(tag, obs_word, exp);
    // Structural invariants of any valid control word.
    check({tag, "_rd_wr_excl"}, W'(o_MemRead & o_MemWrite), '0);
    check({tag, "_br_no_wr"}, W'(o_Branch & o_RegWrite), '0);
    last_exp = exp;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    last_exp = '0;

    // Reset held with an R-format opcode present: outputs stay at NOP.
    i_rst = 1'b1;
    i_opcode = 6'b000000;
    i_control_mux = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    check("reset_nop", obs_word, '0);

    // Release; the first capture happens on the next edge.
    i_rst = 1'b0;
    step("first_r", 6'b000000, 1'b1);
    check("first_r_const", obs_word, WORD_R);

    // Directed decode sequence.
    step("lw",  6'b100011, 1'b1);
    step("sw",  6'b101011, 1'b1);
    step("beq", 6'b000100, 1'b1);

    // Bubble insertion and recovery with BEQ held.
    step("bubble",   6'b000100, 1'b0);
    step("unbubble", 6'b000100, 1'b1);

    // Illegal opcodes decode to the NOP word.
    step("ill_3f", 6'b111111, 1'b1);
    step("ill_08", 6'b001000, 1'b1);

    // Full opcode sweep.
    for (int op = 0; op < 64; op++) begin
      step($sformatf("sweep_%02h", op), 6'(op), 1'b1);
    end

    // Async reset between edges while the outputs show the LW word.
    step("pre_async_lw", 6'b100011, 1'b1);
    #2;
    i_rst = 1'b1;
    #1;
    check("async_rst", obs_word, '0);
    #1;
    i_rst = 1'b0;
    last_exp = '0;
    step("post_async_r", 6'b000000, 1'b1);

    // Randomized traffic, biased toward legal opcodes and normal decode.
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      logic       mux;
      if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
      else                           op = legal_ops[$urandom_range(0, 3)];
      mux = ($urandom_range(0, 4) != 0);
      step("rand", op, mux);
    end

    // Mid-stream reset pulse from a random word, then resume.
    #2;
    i_rst = 1'b1;
    #1;
    check("async_rst2", obs_word, '0);
    @(posedge i_clk);
    #1;
    check("rst_over_edge", obs_word, '0);
    i_rst = 1'b0;
    last_exp = '0;
    step("resume_sw", 6'b101011, 1'b1);

    check("queue_empty", W'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
